// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with run/step/halt debug control
module pc_sequencer #(
    parameter int                   NB_PC       = 32,
    parameter int                   NB_ADDR     = 26,
    parameter int                   NB_UPPER_PC = 4,
    parameter int                   NB_OPCODE   = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_jump,
    input  logic [NB_ADDR-1:0]   i_jump_field,
    input  logic                 i_branch_taken,
    input  logic [NB_PC-1:0]     i_branch_addr,
    input  logic [NB_PC-1:0]     i_pc,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_pc_enable,
    output logic [NB_PC-1:0]     o_next_pc,
    output logic                 o_flush,
    output logic                 o_halted,
    output logic [1:0]           o_state,
    output logic [31:0]          o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_step_pending;
    logic               w_step_pending_next;
    logic               r_step_d;
    logic [31:0]        r_cycle_count;

    logic [NB_PC-1:0]   w_pc_plus1;
    logic [NB_PC-1:0]   w_jump_target;
    logic [NB_PC-1:0]   w_redirect_target;
    logic               w_step_rise;
    logic               w_advance;
    logic               w_redirect;
    logic               w_is_halt_op;
    logic               w_halt_hit;
    logic               w_commit;

    assign w_pc_plus1        = i_pc + NB_PC'(1);
    assign w_jump_target     = {w_pc_plus1[NB_PC-1 -: NB_UPPER_PC], i_jump_field, 2'b00};
    assign w_redirect        = i_branch_taken | i_jump;
    assign w_redirect_target = i_branch_taken ? i_branch_addr : w_jump_target;
    assign w_is_halt_op      = (i_opcode == HALT_OPCODE);
    assign w_step_rise       = i_step & ~r_step_d;
    assign w_advance         = (r_state == ST_RUN) || ((r_state == ST_STEP) && r_step_pending);

    // State, step bookkeeping and the saturating advance-cycle counter
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_step_pending <= 1'b0;
            r_step_d       <= 1'b0;
            r_cycle_count  <= 32'd0;
        end else begin
            r_state        <= w_state_next;
            r_step_pending <= w_step_pending_next;
            r_step_d       <= i_step;
            if (w_advance && (r_cycle_count != 32'hFFFF_FFFF)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
        end
    end

    // PC load decision (redirect beats stall beats halt) and next-state logic
    always_comb begin
        o_pc_enable         = 1'b0;
        o_flush             = 1'b0;
        o_next_pc           = w_pc_plus1;
        w_halt_hit          = 1'b0;
        w_commit            = 1'b0;
        w_state_next        = r_state;
        w_step_pending_next = r_step_pending;

        if (w_advance) begin
            if (w_redirect) begin
                // Fetched instruction is on the wrong path, so its opcode is ignored
                w_commit  = 1'b1;
                o_flush   = 1'b1;
                o_next_pc = w_redirect_target;
            end else if (i_stall) begin
                w_commit = 1'b0;
            end else if (w_is_halt_op) begin
                w_halt_hit = 1'b1;
            end else begin
                w_commit = 1'b1;
            end
        end
        o_pc_enable = w_commit;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = i_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_halt_hit) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                // Edges seen while a step is pending are dropped; steps never queue
                if (r_step_pending) begin
                    if (w_halt_hit) begin
                        w_state_next        = ST_HALT;
                        w_step_pending_next = 1'b0;
                    end else if (w_commit) begin
                        w_step_pending_next = 1'b0;
                    end
                end else if (w_step_rise) begin
                    w_step_pending_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    assign o_halted      = (r_state == ST_HALT);
    assign o_state       = r_state;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic        step;
    logic        stall;
    logic        jump;
    logic [25:0] jump_field;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic        pc_en;
    logic [31:0] next_pc;
    logic        flush;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] cyc;

    int n_checks;
    int n_fail;

    pc_sequencer dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_start        (start),
        .i_mode         (mode),
        .i_step         (step),
        .i_stall        (stall),
        .i_jump         (jump),
        .i_jump_field   (jump_field),
        .i_branch_taken (br_taken),
        .i_branch_addr  (br_addr),
        .i_pc           (pc),
        .i_opcode       (opcode),
        .o_pc_enable    (pc_en),
        .o_next_pc      (next_pc),
        .o_flush        (flush),
        .o_halted       (halted),
        .o_state        (state),
        .o_cycle_count  (cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; mode = 0; step = 0; stall = 0; jump = 0; jump_field = '0;
        br_taken = 0; br_addr = '0; opcode = 6'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        pc       = 32'd0;
        clear_inputs();

        // Reset values
        #12;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_next_pc", next_pc, 32'd1);
        chk("rst_cycles", cyc, 32'd0);
        rst_n = 1;

        // Continuous run from PC 0
        tick();
        start = 1; mode = 0; #1;
        chk("idle_no_adv", {31'd0, pc_en}, 32'd0);
        tick();
        start = 0;
        chk("run_state", {30'd0, state}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            pc = i; #1;
            chk("run_pc_en", {31'd0, pc_en}, 32'd1);
            chk("run_next_pc", next_pc, i + 1);
            tick();
        end
        chk("run_cycles3", cyc, 32'd3);
        pc = 32'hFFFF_FFFF; #1;
        chk("pc_wrap", next_pc, 32'd0);

        // Jump target
        pc = 32'h4000_0010; jump = 1; jump_field = 26'h0000123; #1;
        chk("jump_next_pc", next_pc, 32'h4000_048C);
        chk("jump_flush", {31'd0, flush}, 32'd1);
        chk("jump_pc_en", {31'd0, pc_en}, 32'd1);
        tick();
        jump = 0; pc = 32'h4000_048C; #1;
        chk("post_jump_flush", {31'd0, flush}, 32'd0);
        chk("post_jump_next", next_pc, 32'h4000_048D);

        // Branch beats jump, redirect beats stall
        jump = 1; br_taken = 1; br_addr = 32'h20; stall = 1; #1;
        chk("br_next_pc", next_pc, 32'h20);
        chk("br_pc_en", {31'd0, pc_en}, 32'd1);
        chk("br_flush", {31'd0, flush}, 32'd1);
        tick();
        jump = 0; br_taken = 0; #1;
        chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
        chk("stall_flush", {31'd0, flush}, 32'd0);
        tick();
        stall = 0;
        chk("stall_counted", cyc, 32'd6);

        // HALT opcode on the wrong path is ignored
        pc = 32'd7; opcode = 6'b111111; br_taken = 1; br_addr = 32'h100; #1;
        chk("halt_br_pc_en", {31'd0, pc_en}, 32'd1);
        chk("halt_br_next", next_pc, 32'h100);
        tick();
        chk("halt_br_state", {30'd0, state}, 32'd1);
        br_taken = 0; #1;
        chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
        tick();
        chk("halt_state", {30'd0, state}, 32'd3);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        jump = 1; #1;
        chk("halt_ign_jump", {31'd0, pc_en}, 32'd0);
        chk("halt_ign_flush", {31'd0, flush}, 32'd0);
        tick();
        jump = 0;
        chk("halt_cycles_hold", cyc, 32'd8);
        chk("halt_stays", {30'd0, state}, 32'd3);

        // Start together with HALT opcode: leave IDLE first, halt next cycle
        rst_n = 0; #2; rst_n = 1;
        tick();
        start = 1; mode = 0; opcode = 6'b111111;
        tick();
        start = 0;
        chk("start_halt_run", {30'd0, state}, 32'd1);
        tick();
        chk("start_halt_next", {30'd0, state}, 32'd3);

        // Asynchronous reset mid-RUN
        rst_n = 0; #2; rst_n = 1;
        opcode = 6'd0; pc = 32'h50;
        tick();
        start = 1; mode = 0;
        tick();
        start = 0;
        tick();
        chk("prerst_cycles", cyc, 32'd1);
        jump = 1; jump_field = 26'h3FF;
        rst_n = 0; #2;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_cycles", cyc, 32'd0);
        chk("arst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_next_pc", next_pc, 32'h51);
        #2; rst_n = 1; jump = 0;

        // Single-step: stall during first step, level-held i_step gives one step
        tick();
        start = 1; mode = 1; pc = 32'h10;
        tick();
        start = 0;
        chk("step_state", {30'd0, state}, 32'd2);
        #1;
        chk("step_wait", {31'd0, pc_en}, 32'd0);
        tick();
        step = 1; #1;
        chk("step_edge_not_yet", {31'd0, pc_en}, 32'd0);
        tick();
        stall = 1; #1;
        chk("step_stalled", {31'd0, pc_en}, 32'd0);
        tick();
        stall = 0; #1;
        chk("step1_pc_en", {31'd0, pc_en}, 32'd1);
        chk("step1_next", next_pc, 32'h11);
        tick();
        pc = 32'h11; #1;
        chk("step_held_a", {31'd0, pc_en}, 32'd0);
        tick();
        chk("step_held_b", {31'd0, pc_en}, 32'd0);
        step = 0;
        tick();
        step = 1;
        tick();
        step = 0; #1;
        chk("step2_pc_en", {31'd0, pc_en}, 32'd1);
        chk("step2_next", next_pc, 32'h12);
        tick();
        pc = 32'h12; #1;
        chk("step_done", {31'd0, pc_en}, 32'd0);
        chk("step_cycles", cyc, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block for the fetch stage of the MIPS pipeline. Each cycle it decides whether the program counter advances, and which next-PC source is loaded: sequential PC+1, concatenated J-type jump target, or resolved branch target. It sequences execution for the debug unit: idle, continuous run, single-step, and halt on the HALT opcode. It also drives the IF/ID flush on redirects and keeps a cycle counter for the debug readout.

## Interface
Parameters:
- NB_PC, 32, PC / address width
- NB_ADDR, 26, J-type jump field width
- NB_UPPER_PC, 4, upper PC+1 bits kept in the jump target
- NB_OPCODE, 6, opcode width
- HALT_OPCODE, 6'b111111, opcode that stops execution

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  debug unit start pulse; leaves IDLE
- i_mode  in  1  0 = continuous, 1 = single-step; sampled when leaving IDLE
- i_step  in  1  step request, level; rising edge detected internally
- i_stall  in  1  hazard-unit stall
- i_jump  in  1  decode reports J/JAL
- i_jump_field  in  NB_ADDR  instruction[25:0] of the jump
- i_branch_taken  in  1  branch resolved taken
- i_branch_addr  in  NB_PC  branch target
- i_pc  in  NB_PC  current PC (program counter output)
- i_opcode  in  NB_OPCODE  opcode of the instruction being fetched
- o_pc_enable  out  1  load enable to the program counter
- o_next_pc  out  NB_PC  value the program counter loads
- o_flush  out  1  flush IF/ID
- o_halted  out  1  HALT state reached
- o_state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALT
- o_cycle_count  out  32  advance-cycle counter

## Operation
- pc_plus1 = i_pc + 1, modulo 2^NB_PC. 0xFFFFFFFF wraps to 0.
- Jump target = {pc_plus1[31:28], i_jump_field, 2'b00}, 32 bits.
- Next-PC priority: branch taken > jump > pc_plus1.
- A redirect is a taken branch or a jump.
- "Advance permitted" means state RUN, or state STEP with a pending step.

Advance-permitted cycle, priority order:
1. Redirect: o_pc_enable = 1, o_flush = 1, o_next_pc = redirect target. This happens even when i_stall = 1 (the redirect overrides the stall). The HALT opcode is ignored this cycle, because the fetched instruction is on the wrong path.
2. i_stall = 1 and no redirect: o_pc_enable = 0 and o_flush = 0. A pending step stays pending.
3. i_opcode == HALT_OPCODE: o_pc_enable = 0, so the PC stays on the HALT instruction. Next state is HALT.
4. Otherwise: o_pc_enable = 1, o_next_pc = pc_plus1.

FSM transitions:
- IDLE: i_start goes to RUN if i_mode = 0, or to STEP if i_mode = 1. No advance in IDLE.
- RUN: goes to HALT on the HALT condition; otherwise stays in RUN.
- STEP: a rising edge of i_step sets step_pending. An advance or redirect clears it. The HALT condition clears it and goes to HALT. An edge arriving while a step is already pending is dropped, so steps do not queue.
- HALT: terminal. Only i_reset leaves it. o_halted = 1 and o_pc_enable = 0.

In IDLE and HALT, o_pc_enable = 0 and o_flush = 0, and i_jump / i_branch_taken are ignored.

o_cycle_count:
- Increments by 1 in every cycle with advance permitted, stall cycles included.
- Saturates at 0xFFFFFFFF.
- Holds its value in HALT.

## Timing
- Registered: state, step_pending, i_step edge-detect flop, o_cycle_count.
- Combinational from state and current inputs, with zero-cycle latency: o_pc_enable, o_next_pc, o_flush.
- The PC updates on the same edge that the controller commits.
- Single step: the i_step edge is seen at edge N. The PC advances at edge N+1 if there is no stall. Each further stall cycle adds one cycle.
- Reset (asynchronous, active-low, takes effect mid-operation):
  - state = IDLE, step_pending = 0, edge flop = 0, o_cycle_count = 0.
  - Therefore o_pc_enable = 0, o_flush = 0, o_halted = 0, o_state = 0.
  - o_next_pc = i_pc + 1, which is purely combinational.
- On deassertion, the first active edge behaves as IDLE.
- i_start together with the HALT opcode in the same cycle: the block only leaves IDLE that cycle. HALT is detected on the next cycle.

## Test plan
- Reset, then i_start with i_mode = 0 and i_pc = 0. Expect o_next_pc = 1, 2, 3 on successive cycles with o_pc_enable = 1; o_cycle_count = 3 after 3 cycles.
- RUN, i_pc = 0x40000010, i_jump = 1, i_jump_field = 0x0000123. Expect o_next_pc = 0x4000048C and o_flush = 1 for one cycle.
- RUN, i_jump = 1 and i_branch_taken = 1 with i_branch_addr = 0x20, plus i_stall = 1. Expect o_next_pc = 0x20, o_pc_enable = 1, o_flush = 1.
- STEP mode, i_step pulsed twice with a 1-cycle stall during the first step. Expect exactly two PC advances, the first one delayed one cycle; holding i_step high gives no extra advance.
- RUN, i_opcode = 6'b111111 at i_pc = 7. Expect o_pc_enable = 0, o_state = 3, o_halted = 1, and the PC held at 7. Then check two variants:
  - Repeat the case with i_branch_taken = 1 in the same cycle: expect no halt and a redirect.
  - Assert i_reset = 0 mid-RUN: expect all outputs at their reset values immediately, without a clock edge.
